// File: rtl/car_pw_entry_pkg.sv
// Shared definitions for the car park password entry block.
//   state_t    : entry FSM states
//   DEF_PW_W   : default password width, matching the checker's pw port
//   VERDICT_OK : pw_ok level meaning "code accepted"
//   max3()     : sizing helper for the shared cycle timer
package car_pw_entry_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_OPEN    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   localparam int   DEF_PW_W   = 4;
   localparam logic VERDICT_OK = 1'b1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/car_pw_entry_if.sv
// Request/verdict handshake between the password entry block and the checker.
//   pw       : code under test, stable while pw_valid=1
//   pw_valid : request, held until pw_ack or timeout
//   pw_ack   : verdict strobe from the checker
//   pw_ok    : verdict, sampled with pw_ack
// master = entry block, slave = checker.
interface car_pw_entry_if
   import car_pw_entry_pkg::*;
   #(parameter int PW_W = DEF_PW_W) ();

   logic [PW_W-1:0] pw;
   logic            pw_valid;
   logic            pw_ack;
   logic            pw_ok;

   modport master (output pw, output pw_valid, input pw_ack, input pw_ok);
   modport slave  (input pw, input pw_valid, output pw_ack, output pw_ok);

endinterface

// File: rtl/car_pw_entry_cycle_timer.sv
// Load / count-down / expire timer shared by every timed state.
//   clk, rst : clock and synchronous active-high reset
//   load     : reload count with load_val (wins over counting)
//   load_val : cycles until expiry
//   expired  : high during the last counted cycle, so a state that loads N
//              on entry sees expired on its N-th cycle
module car_cycle_timer #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - W'(1);
   end

   assign expired = (count == W'(1));

endmodule

// File: rtl/car_pw_entry.sv
// Operator-side password entry: shifts in a bit-serial keypad code, offers it
// to the checker over chk, and acts on the verdict (open gate, re-enter
// prompt, or lockout after MAX_TRIES consecutive failures).
//   clk, rst          : clock and synchronous active-high reset
//   key_bit/strobe    : code bit and its shift pulse (MSB first)
//   key_clear         : discard partial entry
//   key_enter         : submit entry
//   chk               : pw/pw_valid out, pw_ack/pw_ok in
//   gate_open         : barrier open command
//   reenter           : one-cycle "key again" prompt
//   locked            : lockout active, keypad ignored
//   fail_cnt          : consecutive failures so far
// All outputs are registered.
module car_pw_entry
   import car_pw_entry_pkg::*;
#(
   parameter int PW_W        = DEF_PW_W,
   parameter int MAX_TRIES   = 3,
   parameter int ACK_TIMEOUT = 32,
   parameter int OPEN_CYCLES = 16,
   parameter int LOCK_CYCLES = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         key_bit,
   input  logic                         key_strobe,
   input  logic                         key_clear,
   input  logic                         key_enter,
   car_pw_entry_if.master               chk,
   output logic                         gate_open,
   output logic                         reenter,
   output logic                         locked,
   output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

   localparam int CNT_W = $clog2(PW_W + 1);
   localparam int FC_W  = $clog2(MAX_TRIES + 1);
   localparam int TMR_W = $clog2(max3(ACK_TIMEOUT, OPEN_CYCLES, LOCK_CYCLES) + 1);

   state_t            state, nxt_state;
   logic [PW_W-1:0]   sr, nxt_sr;
   logic [CNT_W-1:0]  bit_cnt, nxt_bit_cnt;
   logic [PW_W-1:0]   pw_q, nxt_pw;
   logic              pw_valid_q, nxt_pw_valid;
   logic              nxt_gate_open, nxt_reenter, nxt_locked;
   logic [FC_W-1:0]   nxt_fail_cnt, fail_inc;
   logic              tmr_load, tmr_expired;
   logic [TMR_W-1:0]  tmr_val;

   car_cycle_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   assign chk.pw       = pw_q;
   assign chk.pw_valid = pw_valid_q;
   assign fail_inc     = fail_cnt + FC_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         sr         <= '0;
         bit_cnt    <= '0;
         pw_q       <= '0;
         pw_valid_q <= 1'b0;
         gate_open  <= 1'b0;
         reenter    <= 1'b0;
         locked     <= 1'b0;
         fail_cnt   <= '0;
      end else begin
         state      <= nxt_state;
         sr         <= nxt_sr;
         bit_cnt    <= nxt_bit_cnt;
         pw_q       <= nxt_pw;
         pw_valid_q <= nxt_pw_valid;
         gate_open  <= nxt_gate_open;
         reenter    <= nxt_reenter;
         locked     <= nxt_locked;
         fail_cnt   <= nxt_fail_cnt;
      end
   end

   // NOTE: every signal is given a default before the case so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      nxt_state     = state;
      nxt_sr        = sr;
      nxt_bit_cnt   = bit_cnt;
      nxt_pw        = pw_q;
      nxt_pw_valid  = pw_valid_q;
      nxt_gate_open = gate_open;
      nxt_reenter   = 1'b0;
      nxt_locked    = locked;
      nxt_fail_cnt  = fail_cnt;
      tmr_load      = 1'b0;
      tmr_val       = '0;

      unique case (state)
         ST_IDLE: begin
            // Key priority: clear > enter > strobe.
            if (key_clear) begin
               nxt_sr      = '0;
               nxt_bit_cnt = '0;
            end else if (key_enter) begin
               nxt_sr      = '0;
               nxt_bit_cnt = '0;
               if (bit_cnt == CNT_W'(PW_W)) begin
                  nxt_pw       = sr;
                  nxt_pw_valid = 1'b1;
                  nxt_state    = ST_WAIT;
                  tmr_load     = 1'b1;
                  tmr_val      = TMR_W'(ACK_TIMEOUT);
               end else begin
                  nxt_reenter = 1'b1;
               end
            end else if (key_strobe) begin
               // Overlong entries keep shifting; the oldest bit falls off.
               nxt_sr = {sr[PW_W-2:0], key_bit};
               if (bit_cnt != CNT_W'(PW_W))
                  nxt_bit_cnt = bit_cnt + CNT_W'(1);
            end
         end

         ST_WAIT: begin
            // An ack in the same cycle as expiry decides the outcome.
            if (chk.pw_ack && chk.pw_ok == VERDICT_OK) begin
               nxt_pw_valid  = 1'b0;
               nxt_fail_cnt  = '0;
               nxt_gate_open = 1'b1;
               nxt_state     = ST_OPEN;
               tmr_load      = 1'b1;
               tmr_val       = TMR_W'(OPEN_CYCLES);
            end else if (chk.pw_ack || tmr_expired) begin
               nxt_pw_valid = 1'b0;
               nxt_fail_cnt = fail_inc;
               if (fail_inc == FC_W'(MAX_TRIES)) begin
                  // No re-enter prompt while the keypad is locked out.
                  nxt_locked = 1'b1;
                  nxt_state  = ST_LOCKOUT;
                  tmr_load   = 1'b1;
                  tmr_val    = TMR_W'(LOCK_CYCLES);
               end else begin
                  nxt_reenter = 1'b1;
                  nxt_state   = ST_IDLE;
               end
            end
         end

         ST_OPEN: begin
            if (tmr_expired) begin
               nxt_gate_open = 1'b0;
               nxt_state     = ST_IDLE;
            end
         end

         ST_LOCKOUT: begin
            if (tmr_expired) begin
               nxt_locked   = 1'b0;
               nxt_fail_cnt = '0;
               nxt_state    = ST_IDLE;
            end
         end

         default: nxt_state = ST_IDLE;
      endcase
   end

endmodule
